// File: rtl/led_fader.sv
// LED fader: each value_in bit sets a per-LED on/off target, and each LED's PWM
// brightness ramps one step per tick toward it, giving smooth fades on count changes.
module led_fader_lane #(
  parameter int pwm_bits = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                target,
  input  logic [pwm_bits-1:0] pwm_cnt,
  output logic                led,
  output logic                busy
);
  localparam logic [pwm_bits-1:0] MAX = '1;

  logic [pwm_bits-1:0] level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (tick) begin
        if (target && level != MAX)
          level <= level + 1'b1;
        else if (!target && level != '0)
          level <= level - 1'b1;
      end
      led <= (level > pwm_cnt);
    end
  end

  assign busy = target ? (level != MAX) : (level != '0);
endmodule

module led_fader #(
  parameter int width    = 8,
  parameter int pwm_bits = 4,
  parameter int step_div = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] value_in,
  input  logic             value_valid,
  output logic [width-1:0] leds_out,
  output logic             busy
);
  localparam int SW = (step_div > 1) ? $clog2(step_div) : 1;
  localparam logic [pwm_bits-1:0] PWM_LAST  = pwm_bits'((2 ** pwm_bits) - 2);
  localparam logic [SW-1:0]       STEP_LAST = SW'(step_div - 1);

  logic [pwm_bits-1:0] pwm_cnt;
  logic [SW-1:0]       step_cnt;
  logic [width-1:0]    target;
  logic [width-1:0]    lane_busy;
  logic                pwm_wrap;
  logic                tick;

  assign pwm_wrap = (pwm_cnt == PWM_LAST);
  assign tick     = pwm_wrap && (step_cnt == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      target   <= '0;
    end else begin
      pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + 1'b1;
      if (pwm_wrap)
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
      // Lanes sample the old target on a tick that coincides with a strobe.
      if (value_valid)
        target <= value_in;
    end
  end

  for (genvar i = 0; i < width; i++) begin : g_lane
    led_fader_lane #(.pwm_bits(pwm_bits)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .target  (target[i]),
      .pwm_cnt (pwm_cnt),
      .led     (leds_out[i]),
      .busy    (lane_busy[i])
    );
  end

  assign busy = |lane_busy;
endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader at width=4, MAX=3, step_div=2: ticks land on
// every 6th clock edge after reset release.
module tb_led_fader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value_in = 4'h0;
  logic       value_valid = 1'b0;
  logic [3:0] leds_out;
  logic       busy;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  led_fader #(.width(4), .pwm_bits(2), .step_div(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .leds_out    (leds_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Edge count since the last reset release; state at negedge k follows edge k.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) chk("goto_timeout", cyc, k);
  endtask

  task automatic strobe(input int k, input logic [3:0] v);
    goto(k);
    value_in = v;
    value_valid = 1'b1;
    goto(k + 1);
    value_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_leds", leds_out, 4'h0);
    chk("rst_busy", busy, 1'b0);

    // Rise LED0 from 0 to MAX; ticks at edges 6, 12, 18.
    strobe(0, 4'b0001);
    chk("rise_busy", busy, 1'b1);
    goto(7);  chk("l1_p0", leds_out, 4'b0001);
    goto(8);  chk("l1_p1", leds_out, 4'b0000);
    goto(9);  chk("l1_p2", leds_out, 4'b0000);
    goto(10); chk("l1_p0b", leds_out, 4'b0001);
    goto(13); chk("l2_p0", leds_out, 4'b0001);
    goto(14); chk("l2_p1", leds_out, 4'b0001);
    goto(15); chk("l2_p2", leds_out, 4'b0000);
    goto(17); chk("rise_busy17", busy, 1'b1);
    goto(18); chk("rise_done", busy, 1'b0);
    goto(19); chk("l3_p0", leds_out, 4'b0001);

    // Fall LED0 3->2->1->0 at edges 24, 30, 36.
    strobe(19, 4'b0000);
    chk("fall_busy", busy, 1'b1);
    chk("l3_p1", leds_out, 4'b0001);
    goto(21); chk("l3_p2", leds_out, 4'b0001);
    goto(25); chk("f2_p0", leds_out, 4'b0001);
    goto(26); chk("f2_p1", leds_out, 4'b0001);
    goto(27); chk("f2_p2", leds_out, 4'b0000);
    goto(31); chk("f1_p0", leds_out, 4'b0001);
    goto(32); chk("f1_p1", leds_out, 4'b0000);
    goto(35); chk("fall_busy35", busy, 1'b1);
    goto(36); chk("fall_done", busy, 1'b0);
    goto(37); chk("f0_leds", leds_out, 4'b0000);

    // Strobe coinciding with tick at edge 42: that tick uses the old target.
    strobe(37, 4'b0001);
    strobe(41, 4'b0010);
    goto(43); chk("tick_old_target", leds_out, 4'b0001);
    goto(49); chk("tick_new_target", leds_out, 4'b0010);
    chk("tick_busy", busy, 1'b1);

    // Mid-fade reset with level[3]=2, level[1]=1.
    strobe(60, 4'b1000);
    goto(73); chk("pre_rst_leds", leds_out, 4'b1010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", leds_out, 4'b0000);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    goto(12);
    chk("post_rst_leds", leds_out, 4'b0000);
    chk("post_rst_busy", busy, 1'b0);

    // All on, then 0101 after three ticks: LEDs 1/3 return to 0, 0/2 hold at MAX.
    strobe(12, 4'b1111);
    goto(30); chk("all_max_busy", busy, 1'b0);
    strobe(30, 4'b0101);
    chk("all_max_leds", leds_out, 4'b1111);
    chk("rev_busy", busy, 1'b1);
    goto(37); chk("rev2_p0", leds_out, 4'b1111);
    goto(39); chk("rev2_p2", leds_out, 4'b0101);
    goto(47); chk("rev_busy47", busy, 1'b1);
    goto(48); chk("rev_done", busy, 1'b0);
    goto(49); chk("hold_p0", leds_out, 4'b0101);
    goto(50); chk("hold_p1", leds_out, 4'b0101);
    goto(51); chk("hold_p2", leds_out, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
